// File: rtl/pc_fetch_sequencer.sv
// Program counter and single-outstanding instruction fetch sequencer with stall hold and fetch timeout.
// Optional MIPS branch delay slot behaviour is enabled by defining DELAY_SLOT_EN.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic [31:0] pc4_out_o,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [15:0] branch_off_i,
  input  logic        jump_i,
  input  logic [25:0] jump_target_i,
  input  logic        jr_i,
  input  logic [31:0] jr_addr_i,
  output logic        fetch_err_o
);

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_FETCH   = 2'd1,
    S_DELIVER = 2'd2,
    S_ERR     = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(IMEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        redir;
  logic [31:0] redir_pc;

`ifdef DELAY_SLOT_EN
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
`endif

  // Redirect target with jr > jump > branch priority, formed from the delivered pc+4.
  always_comb begin
    redir    = jr_i | jump_i | branch_i;
    redir_pc = pc4_q + {{14{branch_off_i[15]}}, branch_off_i, 2'b00};
    if (jump_i) redir_pc = {pc4_q[31:28], jump_target_i, 2'b00};
    if (jr_i)   redir_pc = jr_addr_i;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef DELAY_SLOT_EN
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
`endif
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          pc4_d   = pc_q + 32'd4;
          valid_d = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_DELIVER;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DELIVER: begin
        if (!stall_i) begin
          valid_d = 1'b0;
          state_d = S_FETCH;
`ifdef DELAY_SLOT_EN
          // The delay-slot instruction always follows sequentially; the redirect lands after it.
          if (pend_q) begin
            pc_d   = pend_tgt_q;
            pend_d = 1'b0;
          end else begin
            pc_d = pc4_q;
            if (redir) begin
              pend_d     = 1'b1;
              pend_tgt_d = redir_pc;
            end
          end
`else
          pc_d = redir ? redir_pc : pc4_q;
`endif
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
`ifdef DELAY_SLOT_EN
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef DELAY_SLOT_EN
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
`endif
    end
  end

  assign imem_req_o    = (state_q == S_FETCH);
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign pc4_out_o     = pc4_q;
  assign fetch_err_o   = err_q;

endmodule
